ysyx_23060221_ifu: RTL

Instruction fetch unit and producer side of the IFU->IDU valid/ready handshake. Holds the architectural PC and issues one word read per instruction to the instruction memory port. Presents the fetched instruction and its PC to the decoder with IFU_valid, then waits for the next PC from the write-back stage before fetching again. The core is strictly multi-cycle, so at most one instruction is in flight.

---
 rtl/ysyx_23060221_ifu_if.sv | 29 ++
 rtl/ysyx_23060221_ifu.sv | 113 +++++++++++
 2 files changed

// File: rtl/ysyx_23060221_ifu_if.sv
// IFU bus bundle: imem request/response, IFU->IDU handoff, WBU next-PC and fault status.
interface ysyx_23060221_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        IFU_valid;
  logic        IDU_ready;
  logic        npc_valid;
  logic [31:0] npc;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  modport master (
    output imem_req_valid, imem_addr, inst, pc, IFU_valid, fetch_fault, fault_cause,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           IDU_ready, npc_valid, npc
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst, pc, IFU_valid, fetch_fault, fault_cause,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           IDU_ready, npc_valid, npc
  );
endinterface

// File: rtl/ysyx_23060221_ifu.sv
// Multi-cycle instruction fetch unit, one instruction in flight, sticky fault state.
// Optional IFU_PERF_EN adds transfer and stall counters as extra output ports.
module ysyx_23060221_ifu #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned MEM_LAT_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_23060221_ifu_if.master  bus
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {S_REQ, S_RESP, S_HAND, S_NPC, S_FAULT} state_t;

  // Limits above the 8-bit saturating counter's reach can never fire.
  localparam logic [8:0] WD_LIM = (MEM_LAT_MAX > 255) ? 9'h1ff : 9'(MEM_LAT_MAX);

  state_t      state, state_n;
  logic [31:0] pc_q, inst_q;
  logic        vld_q;
  logic [1:0]  cause_q;
  logic [7:0]  wd;
  logic        fire, npc_ok, wd_hit;

  assign fire   = vld_q & bus.IDU_ready;
  assign npc_ok = (bus.npc[1:0] == 2'b00);
  assign wd_hit = (MEM_LAT_MAX != 0) && (({1'b0, wd} + 9'd1) >= WD_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_REQ:   if (bus.imem_req_ready) state_n = S_RESP;
      S_RESP: begin
        if (bus.imem_resp_valid) state_n = bus.imem_resp_err ? S_FAULT : S_HAND;
        else if (wd_hit)         state_n = S_FAULT;
      end
      S_HAND:  if (fire) state_n = S_NPC;
      S_NPC:   if (bus.npc_valid) state_n = npc_ok ? S_REQ : S_FAULT;
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_FAULT;
    endcase
  end

  always_comb begin
    bus.imem_req_valid = (state == S_REQ);
    bus.fetch_fault    = (state == S_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      vld_q   <= 1'b0;
      cause_q <= 2'd0;
      wd      <= 8'd0;
    end else begin
      case (state)
        S_REQ: if (bus.imem_req_ready) wd <= 8'd0;
        S_RESP: begin
          if (wd != 8'hff) wd <= wd + 8'd1;
          // A response arriving on the timeout cycle takes priority.
          if (bus.imem_resp_valid) begin
            if (bus.imem_resp_err) begin
              cause_q <= 2'd1;
            end else begin
              inst_q <= bus.imem_resp_data;
              vld_q  <= 1'b1;
            end
          end else if (wd_hit) begin
            cause_q <= 2'd3;
          end
        end
        S_HAND: if (fire) vld_q <= 1'b0;
        S_NPC: begin
          if (bus.npc_valid) begin
            if (npc_ok) pc_q    <= bus.npc;
            else        cause_q <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.inst        = inst_q;
  assign bus.IFU_valid   = vld_q;
  assign bus.fault_cause = cause_q;

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((state == S_REQ && !bus.imem_req_ready) || state == S_RESP)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
